// File: rtl/clock_pkg.sv
// clock_pkg: shared active-low seven-segment codes (gfedcba) and time-field indices for clock display blocks
package clock_pkg;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [1:0] FLD_HOUR  = 2'd2;
  localparam logic [1:0] FLD_MIN   = 2'd1;
  localparam logic [1:0] FLD_SEC   = 2'd0;
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD nibble (bcd) to active-low gfedcba code (seg); values above 9 give blank
module bcd_to_seg7
  import clock_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/time_scan_display.sv
// time_scan_display: scans a per-frame HH-MM-SS snapshot onto an 8-digit active-low 7-seg display (CP clock, CR sync reset, En enable, HH/MM/SS BCD in, BlinkSel {hour,min,sec} blink mask, AN/SEG/DP active-low out)
module time_scan_display
  import clock_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       En,
  input  logic [7:0] HH,
  input  logic [7:0] MM,
  input  logic [7:0] SS,
  input  logic [2:0] BlinkSel,
  output logic [7:0] AN,
  output logic [6:0] SEG,
  output logic       DP
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic [2:0]    idx;
  logic          blink_ph;
  logic [23:0]   snap;
  logic          tick, bwrap, dash, blank;
  logic [3:0]    nib;
  logic [1:0]    fld;
  logic [6:0]    digit_seg, seg_next;
  assign tick  = scan_cnt == SW'(SCAN_DIV - 1);
  assign bwrap = blink_cnt == BW'(BLINK_DIV - 1);
  always_comb begin
    nib  = 4'h0;
    fld  = FLD_SEC;
    dash = 1'b0;
    case (idx)
      3'd7: begin nib = snap[23:20]; fld = FLD_HOUR; end
      3'd6: begin nib = snap[19:16]; fld = FLD_HOUR; end
      3'd4: begin nib = snap[15:12]; fld = FLD_MIN;  end
      3'd3: begin nib = snap[11:8];  fld = FLD_MIN;  end
      3'd1: begin nib = snap[7:4];   fld = FLD_SEC;  end
      3'd0: begin nib = snap[3:0];   fld = FLD_SEC;  end
      default: dash = 1'b1;
    endcase
  end
  bcd_to_seg7 u_seg (
    .bcd(nib),
    .seg(digit_seg)
  );
  // dashes are separators, so the blink mask never applies to them
  assign blank    = !blink_ph && BlinkSel[fld];
  assign seg_next = dash ? SEG_DASH : blank ? SEG_BLANK : digit_seg;
  assign DP       = 1'b1;
  always_ff @(posedge CP) begin
    if (CR) begin
      scan_cnt  <= '0;
      idx       <= 3'd7;
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
      snap      <= '0;
      AN        <= 8'hFF;
      SEG       <= SEG_BLANK;
    end else begin
      scan_cnt  <= tick ? '0 : scan_cnt + 1'b1;
      blink_cnt <= bwrap ? '0 : blink_cnt + 1'b1;
      if (bwrap) blink_ph <= ~blink_ph;
      if (tick) idx <= idx - 3'd1;
      // capture on the last slot of a frame so the next frame starts on coherent data
      if (tick && idx == 3'd0) snap <= {HH, MM, SS};
      AN  <= En ? ~(8'd1 << idx) : 8'hFF;
      SEG <= En ? seg_next : SEG_BLANK;
    end
  end
endmodule

// File: tb/tb_time_scan_display.sv
// tb_time_scan_display: scoreboard bench for time_scan_display with a time-based reference model
module tb_time_scan_display;
  localparam int SD = 4;
  localparam int BD = 16;
  localparam int FRAME = 8 * SD;
  logic       CP = 1'b0;
  logic       CR, En;
  logic [7:0] HH, MM, SS;
  logic [2:0] BlinkSel;
  logic [7:0] AN;
  logic [6:0] SEG;
  logic       DP;
  int total = 0;
  int bad = 0;
  int t = 0;
  bit started = 1'b0;
  logic [23:0] msnap = '0;
  logic [14:0] q[$];
  logic [6:0] tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  time_scan_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .CP(CP), .CR(CR), .En(En), .HH(HH), .MM(MM), .SS(SS),
    .BlinkSel(BlinkSel), .AN(AN), .SEG(SEG), .DP(DP)
  );

  always #5 CP = ~CP;

  // Expected display after the edge that follows 'tt' edges since reset, from the
  // "HH-MM-SS" reading of the snapshot: position 0 is the leftmost character.
  function automatic logic [14:0] expect_out(int tt, logic [23:0] sn, logic en, logic [2:0] bs);
    int pos, field;
    logic [7:0] by;
    logic [3:0] dg;
    logic [6:0] sg;
    logic ph;
    pos = (tt / SD) % 8;
    ph  = ((tt / BD) % 2) == 0;
    if (pos == 2 || pos == 5) sg = 7'h3F;
    else begin
      field = 2 - pos / 3;
      by = sn[8*field +: 8];
      dg = (pos % 3 == 0) ? by[7:4] : by[3:0];
      sg = (dg > 4'd9) ? 7'h7F : tab[dg];
      if (!ph && bs[field]) sg = 7'h7F;
    end
    if (!en) return {8'hFF, 7'h7F};
    return {8'hFF ^ (8'h80 >> pos), sg};
  endfunction

  always @(posedge CP) begin
    if (CR) begin
      t = 0;
      msnap = '0;
      started = 1'b1;
      q.push_back({8'hFF, 7'h7F});
    end else if (started) begin
      q.push_back(expect_out(t, msnap, En, BlinkSel));
      if ((t + 1) % FRAME == 0) msnap = {HH, MM, SS};
      t++;
    end
  end

  always @(negedge CP) begin
    logic [14:0] e;
    if (started) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty t=%0d", t);
      end else begin
        e = q.pop_front();
        if ({AN, SEG} !== e || DP !== 1'b1) begin
          bad++;
          $display("FAIL display t=%0d AN=%h SEG=%h DP=%b expected AN=%h SEG=%h DP=1",
                   t, AN, SEG, DP, e[14:7], e[6:0]);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge CP);
  endtask

  initial begin
    CR = 1'b1; En = 1'b1; HH = 8'h12; MM = 8'h34; SS = 8'h56; BlinkSel = 3'b000;
    step(2);
    CR = 1'b0;
    step(FRAME + 8);
    SS = 8'h57;
    step(FRAME + 20);
    BlinkSel = 3'b100; HH = 8'h23;
    step(3 * FRAME);
    step(13);
    En = 1'b0;
    step(10);
    En = 1'b1;
    step(FRAME);
    HH = 8'hAF; BlinkSel = 3'b000;
    step(2 * FRAME);
    begin
      int guard = 0;
      while ((t / SD) % 8 != 4 && guard < 2 * FRAME) begin
        step(1);
        guard++;
      end
      if (guard >= 2 * FRAME) begin
        bad++;
        $display("FAIL idx3_wait timeout t=%0d", t);
      end
    end
    CR = 1'b1;
    step(1);
    CR = 1'b0;
    step(2 * FRAME);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) HH = 8'($urandom);
      if ($urandom_range(0, 7) == 0) MM = 8'($urandom);
      if ($urandom_range(0, 3) == 0) SS = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 11))};
      if ($urandom_range(0, 15) == 0) BlinkSel = 3'($urandom);
      if ($urandom_range(0, 9) == 0) En = ~En;
      CR = ($urandom_range(0, 149) == 0);
      step(1);
    end
    CR = 1'b0;
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
